// File: rtl/adder_share_arbiter_pkg.sv
// rtl/adder_share_arbiter_pkg.sv - shared constants and state type for the adder share arbiter
package adder_share_arbiter_pkg;

    localparam int DATA_W  = 4;
    localparam int NUM_REQ = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/adder_share_arbiter_fourbitadder.sv
// rtl/adder_share_arbiter_fourbitadder.sv - combinational 4-bit modulo-16 adder, carry discarded
module fourbitadder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Y
);

    assign Y = A + B;

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one 4-bit adder between two requesters
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_RESET = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_id,
    input  logic              rsp_ready,
    output logic              busy
);

    // The pointer stores the last granted requester, so reset loads the
    // opposite of PRIO_RESET to make PRIO_RESET win the first tie.
    localparam logic LAST_RESET = (PRIO_RESET == 0) ? 1'b1 : 1'b0;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
    logic              rsp_id_q, rsp_id_d;
    logic              last_q, last_d;

    logic              slot_free;
    logic              grant;
    logic              grant_id;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] add_y;

    fourbitadder u_adder (
        .A (add_a),
        .B (add_b),
        .Y (add_y)
    );

    always_comb begin
        slot_free = (state_q == IDLE) || rsp_ready;
        grant_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        grant     = !reset && slot_free && (req0_valid || req1_valid);

        add_a = grant_id ? req1_a : req0_a;
        add_b = grant_id ? req1_b : req0_b;

        req0_ready = grant && !grant_id;
        req1_ready = grant && grant_id;

        state_d   = state_q;
        rsp_sum_d = rsp_sum_q;
        rsp_id_d  = rsp_id_q;
        last_d    = last_q;

        // A consumed result is replaced in the same cycle when a request is waiting.
        if (grant) begin
            state_d   = HOLD;
            rsp_sum_d = add_y;
            rsp_id_d  = grant_id;
            last_d    = grant_id;
        end else if (state_q == HOLD && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rsp_sum_q <= '0;
            rsp_id_q  <= 1'b0;
            last_q    <= LAST_RESET;
        end else begin
            state_q   <= state_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_id_q  <= rsp_id_d;
            last_q    <= last_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign busy      = (state_q == HOLD);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

    localparam int PRIO = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req1_ready;
    logic       rsp_valid;
    logic [3:0] rsp_sum;
    logic       rsp_id;
    logic       rsp_ready;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: what the result slot should hold and who was granted last (-1 = none since reset).
    bit       m_valid;
    bit [3:0] m_sum;
    bit       m_id;
    int       m_last;
    int       exp_g;
    bit       obs_r0;
    bit       obs_r1;

    always #5 clk = ~clk;

    adder_share_arbiter #(.PRIO_RESET(PRIO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    function automatic int pick(input bit r, input bit v0, input bit v1, input bit rr);
        if (r) return -1;
        if (m_valid && !rr) return -1;
        if (v0 && v1) return (m_last < 0) ? PRIO : 1 - m_last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic do_cycle(input bit r, input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                            input bit v1, input logic [3:0] a1, input logic [3:0] b1, input bit rr);
        reset      = r;
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        rsp_ready  = rr;
        #1;
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        exp_g  = pick(r, v0, v1, rr);
        @(posedge clk);
        if (r) begin
            m_valid = 0;
            m_sum   = 0;
            m_id    = 0;
            m_last  = -1;
        end else if (exp_g >= 0) begin
            m_valid = 1;
            m_id    = exp_g[0];
            m_sum   = (exp_g == 0) ? 4'((int'(a0) + int'(b0)) % 16) : 4'((int'(a1) + int'(b1)) % 16);
            m_last  = exp_g;
        end else if (rr) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            do_cycle(1, 1, 4'd3, 4'd4, 1, 4'd5, 4'd6, 1);
            tests_run++;
            if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_ready: got r0=%0b r1=%0b, expected 0 0", obs_r0, obs_r1);
            end
            tests_run++;
            if (rsp_valid !== 1'b0 || rsp_sum !== 4'd0 || busy !== 1'b0 || rsp_id !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got valid=%0b sum=%0d busy=%0b id=%0b, expected 0 0 0 0",
                         rsp_valid, rsp_sum, busy, rsp_id);
            end
        end
    endtask

    task automatic test_single;
        do_cycle(0, 1, 4'd3, 4'd4, 0, 4'd0, 4'd0, 1);
        tests_run++;
        if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ready: got r0=%0b r1=%0b, expected 1 0", obs_r0, obs_r1);
        end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 4'd7 || rsp_id !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_rsp: got valid=%0b sum=%0d id=%0b busy=%0b, expected 1 7 0 1",
                     rsp_valid, rsp_sum, rsp_id, busy);
        end
        do_cycle(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
        tests_run++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: got valid=%0b busy=%0b, expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] ops [2][2];
        logic [3:0] sums [2];
        ops[0][0] = 4'd9;  ops[0][1] = 4'd8;  sums[0] = 4'd1;
        ops[1][0] = 4'd15; ops[1][1] = 4'd15; sums[1] = 4'd14;
        for (int i = 0; i < 2; i++) begin
            do_cycle(0, 0, 4'd0, 4'd0, 1, ops[i][0], ops[i][1], 1);
            tests_run++;
            if (obs_r1 !== 1'b1 || rsp_sum !== sums[i] || rsp_id !== 1'b1 || rsp_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL wrap_%0d: got r1=%0b sum=%0d id=%0b valid=%0b, expected 1 %0d 1 1",
                         i, obs_r1, rsp_sum, rsp_id, rsp_valid, sums[i]);
            end
        end
        do_cycle(0, 1, 4'd15, 4'd1, 0, 4'd0, 4'd0, 1);
        tests_run++;
        if (rsp_sum !== 4'd0 || rsp_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_15p1: got sum=%0d id=%0b, expected 0 0", rsp_sum, rsp_id);
        end
        do_cycle(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
    endtask

    task automatic test_simultaneous;
        do_cycle(1, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 1, 4'd1, 4'd1, 1, 4'd2, 4'd2, 1);
            tests_run++;
            if (obs_r0 !== (i % 2 == 0) || obs_r1 !== (i % 2 == 1)) begin
                tests_failed++;
                $display("FAIL tie_grant_%0d: got r0=%0b r1=%0b, expected grant %0d", i, obs_r0, obs_r1, i % 2);
            end
            tests_run++;
            if (rsp_id !== 1'(i % 2) || rsp_sum !== ((i % 2 == 0) ? 4'd2 : 4'd4) || rsp_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL tie_rsp_%0d: got id=%0b sum=%0d valid=%0b, expected %0d %0d 1",
                         i, rsp_id, rsp_sum, rsp_valid, i % 2, (i % 2 == 0) ? 2 : 4);
            end
        end
        do_cycle(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
    endtask

    task automatic test_backpressure;
        do_cycle(0, 1, 4'd3, 4'd4, 0, 4'd0, 4'd0, 1);
        for (int i = 0; i < 5; i++) begin
            do_cycle(0, 0, 4'd0, 4'd0, 1, 4'd5, 4'd6, 0);
            tests_run++;
            if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0 || rsp_sum !== 4'd7 || rsp_id !== 1'b0 || rsp_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL backpressure_%0d: got r1=%0b sum=%0d id=%0b valid=%0b, expected 0 7 0 1",
                         i, obs_r1, rsp_sum, rsp_id, rsp_valid);
            end
        end
        do_cycle(0, 0, 4'd0, 4'd0, 1, 4'd5, 4'd6, 1);
        tests_run++;
        if (obs_r1 !== 1'b1 || rsp_sum !== 4'd11 || rsp_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: got r1=%0b sum=%0d id=%0b, expected 1 11 1", obs_r1, rsp_sum, rsp_id);
        end
        do_cycle(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
    endtask

    task automatic test_reset_mid;
        do_cycle(0, 0, 4'd0, 4'd0, 1, 4'd3, 4'd4, 0);
        do_cycle(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 4'd7) begin
            tests_failed++;
            $display("FAIL reset_mid_hold: got valid=%0b sum=%0d, expected 1 7", rsp_valid, rsp_sum);
        end
        do_cycle(1, 1, 4'd1, 4'd1, 1, 4'd2, 4'd2, 1);
        tests_run++;
        if (rsp_valid !== 1'b0 || obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_drop: got valid=%0b r0=%0b r1=%0b, expected 0 0 0", rsp_valid, obs_r0, obs_r1);
        end
        do_cycle(0, 1, 4'd1, 4'd1, 1, 4'd2, 4'd2, 1);
        tests_run++;
        if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0 || rsp_id !== 1'b0 || rsp_sum !== 4'd2) begin
            tests_failed++;
            $display("FAIL reset_mid_prio: got r0=%0b r1=%0b id=%0b sum=%0d, expected 1 0 0 2",
                     obs_r0, obs_r1, rsp_id, rsp_sum);
        end
        do_cycle(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
    endtask

    task automatic test_random;
        bit         p0 = 0, p1 = 0, rr, r;
        logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && ($urandom % 3 != 0)) begin p0 = 1; a0 = 4'($urandom); b0 = 4'($urandom); end
            if (!p1 && ($urandom % 3 != 0)) begin p1 = 1; a1 = 4'($urandom); b1 = 4'($urandom); end
            rr = ($urandom % 4 != 0);
            r  = ($urandom % 60 == 0);
            do_cycle(r, p0, a0, b0, p1, a1, b1, rr);
            tests_run++;
            if (obs_r0 !== (exp_g == 0) || obs_r1 !== (exp_g == 1)) begin
                tests_failed++;
                $display("FAIL rand_ready_%0d: got r0=%0b r1=%0b, expected grant %0d", i, obs_r0, obs_r1, exp_g);
            end
            tests_run++;
            if (rsp_valid !== m_valid || busy !== m_valid ||
                (m_valid && (rsp_sum !== m_sum || rsp_id !== m_id))) begin
                tests_failed++;
                $display("FAIL rand_rsp_%0d: got valid=%0b busy=%0b sum=%0d id=%0b, expected valid=%0b sum=%0d id=%0b",
                         i, rsp_valid, busy, rsp_sum, rsp_id, m_valid, m_sum, m_id);
            end
            if (obs_r0) p0 = 0;
            if (obs_r1) p1 = 0;
        end
    endtask

    initial begin
        reset = 1; req0_valid = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; rsp_ready = 0;
        m_valid = 0; m_sum = 0; m_id = 0; m_last = -1;
        @(posedge clk);
        #1;
        test_reset;
        test_single;
        test_wrap;
        test_simultaneous;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
